// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Instruction-fetch sequencer: PC ownership, imem req/ack fetch,
//            valid/stall hand-off to decode and branch/jump redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imemReq,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic              imemAck,
    input  logic [DATA_W-1:0] imemData,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirectAddr,
    output logic              instrValid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pcOut,
    output logic              misalign
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_valid;
    logic [DATA_W-1:0]   r_instr;
    logic [ADDR_W-1:0]   r_pc_out;
    logic                r_misalign;
    logic                w_req;
    logic                w_handshake;
    logic                w_consume;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_redirect_pc;

    // A held instruction under stall blocks new requests so it cannot be overwritten.
    assign w_req         = rst_n && (r_state == S_FETCH) && !(r_valid && stall) && !redirect;
    assign w_handshake   = w_req && imemAck;
    assign w_consume     = r_valid && !stall;
    assign w_pc_inc      = r_pc + c_PC_STEP;
    assign w_redirect_pc = {redirectAddr[ADDR_W-1:2], 2'b00};

    always_comb begin
        w_state_nxt = r_state;
        if (redirect) begin
            w_state_nxt = S_FLUSH;
        end else if (r_state == S_FLUSH) begin
            w_state_nxt = S_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_ADDR;
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_pc_out   <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            if (redirect) begin
                r_pc       <= w_redirect_pc;
                r_valid    <= 1'b0;
                r_misalign <= (redirectAddr[1:0] != 2'b00);
            end else if (w_handshake) begin
                r_instr  <= imemData;
                r_pc_out <= r_pc;
                r_valid  <= 1'b1;
                r_pc     <= w_pc_inc;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign imemReq    = w_req;
    assign imemAddr   = r_pc;
    assign instrValid = r_valid;
    assign instr      = r_instr;
    assign pcOut      = r_pc_out;
    assign misalign   = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Directed vector-table bench for fetch_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectAddr;
    logic        instrValid;
    logic [31:0] instr;
    logic [31:0] pcOut;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    fetch_sequencer #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemAck      (imemAck),
        .imemData     (imemData),
        .stall        (stall),
        .redirect     (redirect),
        .redirectAddr (redirectAddr),
        .instrValid   (instrValid),
        .instr        (instr),
        .pcOut        (pcOut),
        .misalign     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] data;
        logic        stl;
        logic        rdr;
        logic [31:0] raddr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    function automatic vec_t mk(logic ack, logic [31:0] data, logic stl, logic rdr,
                                logic [31:0] raddr, logic e_req, logic [31:0] e_addr,
                                logic e_valid, logic [31:0] e_pc, logic [31:0] e_instr,
                                logic e_mis);
        vec_t v;
        v.ack = ack;     v.data = data;     v.stl = stl;       v.rdr = rdr;
        v.raddr = raddr; v.e_req = e_req;   v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pc = e_pc;   v.e_instr = e_instr; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // Inputs for each step are applied at the falling edge; the expected
        // registered outputs reflect the preceding rising edges.
        //          ack  data           stl  rdr  raddr          req  addr           vld  pcOut          instr          mis
        vecs[0]  = mk(1, 32'h1000_0000, 0, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000, 0);
        vecs[1]  = mk(1, 32'h1000_0004, 0, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0000_0000, 32'h1000_0000, 0);
        vecs[2]  = mk(1, 32'h1000_0008, 0, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0004, 32'h1000_0004, 0);
        vecs[3]  = mk(1, 32'h1000_000C, 1, 0, 32'h0,         0, 32'h0000_000C, 1, 32'h0000_0008, 32'h1000_0008, 0);
        vecs[4]  = mk(1, 32'h1000_000C, 1, 0, 32'h0,         0, 32'h0000_000C, 1, 32'h0000_0008, 32'h1000_0008, 0);
        vecs[5]  = mk(1, 32'h1000_000C, 1, 0, 32'h0,         0, 32'h0000_000C, 1, 32'h0000_0008, 32'h1000_0008, 0);
        vecs[6]  = mk(1, 32'h1000_000C, 0, 0, 32'h0,         1, 32'h0000_000C, 1, 32'h0000_0008, 32'h1000_0008, 0);
        vecs[7]  = mk(0, 32'h0000_0000, 0, 0, 32'h0,         1, 32'h0000_0010, 1, 32'h0000_000C, 32'h1000_000C, 0);
        vecs[8]  = mk(0, 32'h0000_0000, 0, 0, 32'h0,         1, 32'h0000_0010, 0, 32'h0000_000C, 32'h1000_000C, 0);
        vecs[9]  = mk(1, 32'h1000_0010, 0, 1, 32'h0000_0100, 0, 32'h0000_0010, 0, 32'h0000_000C, 32'h1000_000C, 0);
        vecs[10] = mk(1, 32'h1000_0010, 0, 0, 32'h0,         0, 32'h0000_0100, 0, 32'h0000_000C, 32'h1000_000C, 0);
        vecs[11] = mk(0, 32'h0000_0000, 0, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0000_000C, 32'h1000_000C, 0);
        vecs[12] = mk(1, 32'h1000_0100, 0, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0000_000C, 32'h1000_000C, 0);
        vecs[13] = mk(0, 32'h0000_0000, 1, 1, 32'h0000_0203, 0, 32'h0000_0104, 1, 32'h0000_0100, 32'h1000_0100, 0);
        vecs[14] = mk(1, 32'h1000_0104, 0, 0, 32'h0,         0, 32'h0000_0200, 0, 32'h0000_0100, 32'h1000_0100, 1);
        vecs[15] = mk(1, 32'h1000_0200, 0, 0, 32'h0,         1, 32'h0000_0200, 0, 32'h0000_0100, 32'h1000_0100, 0);
        vecs[16] = mk(1, 32'h1000_0204, 0, 1, 32'hFFFF_FFF8, 0, 32'h0000_0204, 1, 32'h0000_0200, 32'h1000_0200, 0);
        vecs[17] = mk(1, 32'h1000_0204, 0, 0, 32'h0,         0, 32'hFFFF_FFF8, 0, 32'h0000_0200, 32'h1000_0200, 0);
        vecs[18] = mk(1, 32'hE000_FFF8, 0, 0, 32'h0,         1, 32'hFFFF_FFF8, 0, 32'h0000_0200, 32'h1000_0200, 0);
        vecs[19] = mk(1, 32'hE000_FFFC, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 32'hE000_FFF8, 0);
        vecs[20] = mk(1, 32'hE000_0000, 0, 0, 32'h0,         1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'hE000_FFFC, 0);
        vecs[21] = mk(0, 32'h0000_0000, 1, 0, 32'h0,         0, 32'h0000_0004, 1, 32'h0000_0000, 32'hE000_0000, 0);

        rst_n = 1'b0;
        imemAck = 1'b1;
        imemData = 32'hBAD0_BAD0;
        stall = 1'b0;
        redirect = 1'b0;
        redirectAddr = '0;

        // Reset state, with an ack present that must be ignored.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req",      -1, {31'b0, imemReq},    32'h0);
        chk("rst_addr",     -1, imemAddr,            32'h0);
        chk("rst_valid",    -1, {31'b0, instrValid}, 32'h0);
        chk("rst_instr",    -1, instr,               32'h0);
        chk("rst_pcOut",    -1, pcOut,               32'h0);
        chk("rst_misalign", -1, {31'b0, misalign},   32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            if (i > 0) @(negedge clk);
            imemAck      = vecs[i].ack;
            imemData     = vecs[i].data;
            stall        = vecs[i].stl;
            redirect     = vecs[i].rdr;
            redirectAddr = vecs[i].raddr;
            #1;
            chk("imemReq",    i, {31'b0, imemReq},    {31'b0, vecs[i].e_req});
            chk("imemAddr",   i, imemAddr,            vecs[i].e_addr);
            chk("instrValid", i, {31'b0, instrValid}, {31'b0, vecs[i].e_valid});
            chk("pcOut",      i, pcOut,               vecs[i].e_pc);
            chk("instr",      i, instr,               vecs[i].e_instr);
            chk("misalign",   i, {31'b0, misalign},   {31'b0, vecs[i].e_mis});
        end

        // Async reset mid-cycle while a stalled instruction is held.
        @(negedge clk);
        imemAck = 1'b1;
        imemData = 32'h5555_0000;
        stall = 1'b1;
        redirect = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 100, {31'b0, instrValid}, 32'h0);
        chk("arst_req",   100, {31'b0, imemReq},    32'h0);
        chk("arst_addr",  100, imemAddr,            32'h0);
        chk("arst_pcOut", 100, pcOut,               32'h0);
        chk("arst_instr", 100, instr,               32'h0);

        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_hold_valid", 101, {31'b0, instrValid}, 32'h0);
        chk("arst_hold_addr",  101, imemAddr,            32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        imemAck = 1'b0;
        #1;
        chk("rel_req",  102, {31'b0, imemReq}, 32'h1);
        chk("rel_addr", 102, imemAddr,         32'h0);
        @(posedge clk);
        #1;
        chk("rel_wait_valid", 103, {31'b0, instrValid}, 32'h0);
        chk("rel_wait_addr",  103, imemAddr,            32'h0);

        @(negedge clk);
        imemAck = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ack_valid", 104, {31'b0, instrValid}, 32'h1);
        chk("rel_ack_pcOut", 104, pcOut,               32'h0);
        chk("rel_ack_instr", 104, instr,               32'h5555_0000);
        chk("rel_ack_addr",  104, imemAddr,            32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
